// File: rtl/fp_accum_ctrl_pkg.sv
// Shared types and constants for the floating-point accumulation controller.
// Holds the FSM state encoding and the FP16 constants used by the block and its bench.
package fp_accum_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    ADD_WAIT = 2'd2,
    OUT      = 2'd3
  } fp_accum_state_t;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

endpackage

// File: rtl/fp_accum_ctrl.sv
// Sequences an external floating-point adder to sum groups of FP elements in arrival order.
// No arithmetic happens here; operands and results pass through untouched.
module fp_accum_ctrl
  import fp_accum_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  add_en,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic                  add_ready,
  input  logic [DATA_WIDTH-1:0] add_result,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  fp_accum_state_t       state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] add_a_q, add_a_d;
  logic [DATA_WIDTH-1:0] add_b_q, add_b_d;
  logic                  last_q, last_d;
  logic                  in_hs;

  assign in_hs = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      last_q  <= last_d;
    end
  end

  // add_ready is only looked at in ADD_WAIT, i.e. only while add_en is high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_hs) state_d = in_last ? OUT : ACCUM;
      ACCUM:    if (in_hs) state_d = ADD_WAIT;
      ADD_WAIT: if (add_ready) state_d = last_q ? OUT : ACCUM;
      OUT:      if (out_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (in_hs) acc_d = in_data;
      end
      ACCUM: begin
        if (in_hs) begin
          add_a_d = acc_q;
          add_b_d = in_data;
          last_d  = in_last;
        end
      end
      ADD_WAIT: begin
        if (add_ready) acc_d = add_result;
      end
      OUT: begin
        if (out_ready) acc_d = '0;
      end
    endcase
  end

  // in_ready is gated by reset so nothing is offered during the reset cycle.
  always_comb begin
    in_ready  = !reset && ((state_q == IDLE) || (state_q == ACCUM));
    add_en    = (state_q == ADD_WAIT);
    out_valid = (state_q == OUT);
    out_data  = acc_q;
    add_a     = add_a_q;
    add_b     = add_b_q;
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl with a behavioural FP16 adder and an output scoreboard.
module tb_fp_accum_ctrl;
  import fp_accum_ctrl_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_last, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, add_en, add_ready, out_valid;
  logic [DW-1:0] add_a, add_b, add_result, out_data;
  logic          manual_ready;
  logic [DW-1:0] manual_result;

  logic          model_ready = 1'b0;
  logic [DW-1:0] model_result = '0;
  logic          auto_en = 1'b1;
  int            lat = 3;
  logic          busy = 1'b0;
  int            cnt = 0;
  logic [DW-1:0] cap_a = '0, cap_b = '0;
  logic [DW-1:0] op_a [4];
  logic [DW-1:0] op_b [4];
  int            req_total = 0, stab_viol = 0, rdy_viol = 0, en_cycles = 0;

  int            chk_cnt = 0, pass_cnt = 0;
  logic [DW-1:0] exp_q [$];

  fp_accum_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_ready(add_ready), .add_result(add_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Positive-normal FP16 add with truncation; enough for the stimulus used here.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  ex, ey;
    logic [11:0] mx, my, s;
    if (a[14:10] < b[14:10]) begin x = b; y = a; end else begin x = a; y = b; end
    ex = x[14:10];
    ey = y[14:10];
    mx = {2'b01, x[9:0]};
    my = {2'b01, y[9:0]} >> (ex - ey);
    s  = mx + my;
    if (s[11]) begin s = s >> 1; ex = ex + 5'd1; end
    return {1'b0, ex, s[9:0]};
  endfunction

  assign add_ready  = model_ready | manual_ready;
  assign add_result = model_ready ? model_result : manual_result;

  // Behavioural adder: accepts a request on add_en, answers after lat cycles.
  always @(posedge clk) begin
    model_ready <= 1'b0;
    if (add_en) en_cycles <= en_cycles + 1;
    if (add_en && in_ready) rdy_viol <= rdy_viol + 1;
    if (reset || !auto_en) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (add_en && (add_a !== cap_a || add_b !== cap_b)) stab_viol <= stab_viol + 1;
      if (cnt <= 1) begin
        model_ready  <= 1'b1;
        model_result <= fp16_add(cap_a, cap_b);
        busy         <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (add_en && !model_ready) begin
      busy  <= 1'b1;
      cnt   <= lat;
      cap_a <= add_a;
      cap_b <= add_b;
      op_a[req_total % 4] <= add_a;
      op_b[req_total % 4] <= add_b;
      req_total <= req_total + 1;
    end
  end

  // All tasks start and end on a falling edge.
  task automatic send(input logic [15:0] d, input logic last, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    ok = out_valid;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (add_en !== 1'b0) $display("FAIL reset_add_en: got %b want 0", add_en); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== FP16_ZERO || add_a !== FP16_ZERO || add_b !== FP16_ZERO)
      $display("FAIL reset_data: got out=%h a=%h b=%h want 0", out_data, add_a, add_b); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else pass_cnt++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single();
    bit ok;
    int r0, e0;
    logic [15:0] e;
    r0 = req_total; e0 = en_cycles;
    exp_q.push_back(16'h4E00);
    send(16'h4E00, 1'b1, ok);
    chk_cnt++; if (!ok) $display("FAIL single_send: in_ready stuck low"); else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== e)
      $display("FAIL single_out: got valid=%b data=%h want 1/%h", out_valid, out_data, e); else pass_cnt++;
    chk_cnt++; if (en_cycles != e0 || req_total != r0)
      $display("FAIL single_no_add: got %0d add_en cycles want 0", en_cycles - e0); else pass_cnt++;
    accept_out();
    $display("single: in=4e00 out=%h", out_data);
  endtask

  task automatic test_stream();
    bit ok, ok1, ok2, ok3;
    int r0;
    logic [15:0] e;
    lat = 3; r0 = req_total;
    exp_q.push_back(16'h4600);
    send(FP16_ONE, 1'b0, ok1);
    send(16'h4000, 1'b0, ok2);
    send(16'h4200, 1'b1, ok3);
    wait_out(ok);
    chk_cnt++; if (!(ok && ok1 && ok2 && ok3)) $display("FAIL stream_timeout: handshake or output bound expired"); else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++; if (out_data !== e) $display("FAIL stream_sum: got %h want %h", out_data, e); else pass_cnt++;
    chk_cnt++; if (req_total - r0 != 2) $display("FAIL stream_requests: got %0d want 2", req_total - r0); else pass_cnt++;
    chk_cnt++; if (op_a[r0 % 4] !== 16'h3C00 || op_b[r0 % 4] !== 16'h4000)
      $display("FAIL stream_op0: got %h+%h want 3c00+4000", op_a[r0 % 4], op_b[r0 % 4]); else pass_cnt++;
    chk_cnt++; if (op_a[(r0 + 1) % 4] !== 16'h4200 || op_b[(r0 + 1) % 4] !== 16'h4200)
      $display("FAIL stream_op1: got %h+%h want 4200+4200", op_a[(r0 + 1) % 4], op_b[(r0 + 1) % 4]); else pass_cnt++;
    accept_out();
    $display("stream: 3c00,4000,4200 -> %h", e);
  endtask

  task automatic test_long_latency();
    bit ok, ok1, ok2;
    int r0, rv0, sv0, e0;
    logic [15:0] e;
    lat = 10; r0 = req_total; rv0 = rdy_viol; sv0 = stab_viol; e0 = en_cycles;
    exp_q.push_back(16'h4500);
    send(16'h4400, 1'b0, ok1);
    send(16'h3C00, 1'b1, ok2);
    wait_out(ok);
    chk_cnt++; if (!(ok && ok1 && ok2)) $display("FAIL long_timeout: handshake or output bound expired"); else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++; if (out_data !== e) $display("FAIL long_sum: got %h want %h", out_data, e); else pass_cnt++;
    chk_cnt++; if (req_total - r0 != 1) $display("FAIL long_requests: got %0d want 1", req_total - r0); else pass_cnt++;
    chk_cnt++; if (rdy_viol != rv0) $display("FAIL long_in_ready: got %0d cycles high during add_en want 0", rdy_viol - rv0); else pass_cnt++;
    chk_cnt++; if (stab_viol != sv0) $display("FAIL long_stable: got %0d operand changes want 0", stab_viol - sv0); else pass_cnt++;
    chk_cnt++; if (en_cycles - e0 < 10) $display("FAIL long_hold: got %0d add_en cycles want >=10", en_cycles - e0); else pass_cnt++;
    accept_out();
    lat = 3;
    $display("long_latency: 4400+3c00 -> %h", e);
  endtask

  task automatic test_backpressure();
    bit ok, ok1, ok2;
    logic [15:0] e;
    exp_q.push_back(16'h4000);
    send(FP16_ONE, 1'b0, ok1);
    send(FP16_ONE, 1'b1, ok2);
    wait_out(ok);
    chk_cnt++; if (!(ok && ok1 && ok2)) $display("FAIL bp_timeout: handshake or output bound expired"); else pass_cnt++;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b data=%h in_ready=%b want 1/%h/0", i, out_valid, out_data, in_ready, e);
      else pass_cnt++;
      @(negedge clk);
    end
    accept_out();
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    exp_q.push_back(16'h3800);
    send(16'h3800, 1'b1, ok);
    e = exp_q.pop_front();
    chk_cnt++; if (!ok || out_data !== e) $display("FAIL bp_next_group: got %h want %h", out_data, e); else pass_cnt++;
    accept_out();
    $display("backpressure: held 5 cycles, next group out=%h", e);
  endtask

  task automatic test_passthrough();
    bit ok;
    logic [15:0] vals [2];
    logic [15:0] e;
    vals[0] = 16'h7E01;
    vals[1] = 16'hFC00;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(vals[i]);
      send(vals[i], 1'b1, ok);
      e = exp_q.pop_front();
      chk_cnt++; if (!ok || out_data !== e) $display("FAIL passthrough%0d: got %h want %h", i, out_data, e); else pass_cnt++;
      accept_out();
      $display("passthrough: in=%h out=%h", vals[i], e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok1, ok2;
    logic [15:0] e;
    auto_en = 1'b0;
    send(16'h4000, 1'b0, ok1);
    send(16'h4000, 1'b1, ok2);
    chk_cnt++; if (!(ok1 && ok2) || add_en !== 1'b1) $display("FAIL mid_in_add_wait: got add_en=%b want 1", add_en); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    manual_result = 16'h7BFF;
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    @(negedge clk);
    chk_cnt++; if (add_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_ctrl: got add_en=%b valid=%b in_ready=%b want 0/0/1", add_en, out_valid, in_ready); else pass_cnt++;
    chk_cnt++; if (out_data !== FP16_ZERO || add_a !== FP16_ZERO || add_b !== FP16_ZERO)
      $display("FAIL mid_data: got out=%h a=%h b=%h want 0", out_data, add_a, add_b); else pass_cnt++;
    auto_en = 1'b1;
    lat = 2;
    exp_q.push_back(16'h4400);
    send(16'h4000, 1'b0, ok1);
    send(16'h4000, 1'b1, ok2);
    wait_out(ok);
    e = exp_q.pop_front();
    chk_cnt++; if (!(ok && ok1 && ok2) || out_data !== e) $display("FAIL mid_next_sum: got %h want %h", out_data, e); else pass_cnt++;
    accept_out();
    $display("reset_mid: aborted group, next sum=%h", e);
  endtask

  task automatic test_back_to_back();
    bit ok, oks;
    int n, r0;
    logic [15:0] v, sum, e;
    for (int g = 0; g < 6; g++) begin
      lat = $urandom_range(1, 4);
      n = $urandom_range(1, 5);
      r0 = req_total;
      oks = 1'b1;
      sum = '0;
      for (int k = 0; k < n; k++) begin
        v = {1'b0, 5'($urandom_range(12, 15)), 10'($urandom)};
        sum = (k == 0) ? v : fp16_add(sum, v);
        if (k == n - 1) exp_q.push_back(sum);
        send(v, (k == n - 1), ok);
        oks = oks && ok;
      end
      wait_out(ok);
      e = exp_q.pop_front();
      chk_cnt++; if (!(ok && oks) || out_data !== e)
        $display("FAIL b2b_sum%0d: got %h want %h", g, out_data, e); else pass_cnt++;
      chk_cnt++; if (req_total - r0 != n - 1)
        $display("FAIL b2b_requests%0d: got %0d want %0d", g, req_total - r0, n - 1); else pass_cnt++;
      accept_out();
      $display("back_to_back: group %0d n=%0d lat=%0d sum=%h", g, n, lat, e);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; manual_ready = 1'b0; manual_result = '0;
    test_reset();
    test_single();
    test_stream();
    test_long_latency();
    test_backpressure();
    test_passthrough();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_accum_ctrl.md
FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the floating-point operand width (IEEE half for 16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  input element offered.
REQ-005 SHALL have port in_ready  output  1  block accepts element this cycle.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  FP element.
REQ-007 SHALL have port in_last  input  1  element is last of the current sum group.
REQ-008 SHALL have port add_en  output  1  request to the external floating_point_adder.
REQ-009 SHALL have port add_a  output  DATA_WIDTH  adder operand A (running sum).
REQ-010 SHALL have port add_b  output  DATA_WIDTH  adder operand B (new element).
REQ-011 SHALL have port add_ready  input  1  one-cycle pulse: add_result valid.
REQ-012 SHALL have port add_result  input  DATA_WIDTH  adder sum.
REQ-013 SHALL have port out_valid  output  1  group sum available.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  group sum.
REQ-015 SHALL have port out_ready  input  1  downstream accepts sum.

Function
REQ-016 SHALL be the initiator of the adder en/ready protocol: add_en held high with add_a/add_b stable from issue until the cycle add_ready is sampled high, inclusive.
REQ-017 SHALL drop add_en the cycle after add_ready and keep it low at least one cycle before any new request.
REQ-018 SHALL ignore add_ready while add_en is low.
REQ-019 SHALL use FSM states IDLE, ACCUM, ADD_WAIT, OUT.
REQ-020 IDLE: in_ready=1; on in_valid, acc<=in_data; in_last -> OUT, else -> ACCUM; no adder request.
REQ-021 ACCUM: in_ready=1; on in_valid, latch in_data into add_b and last flag, add_a<=acc, -> ADD_WAIT.
REQ-022 ADD_WAIT: in_ready=0, add_en=1; on add_ready, acc<=add_result; latched last -> OUT, else -> ACCUM.
REQ-023 OUT: out_valid=1, out_data=acc stable; on out_ready -> IDLE (acc cleared to 0); in_ready=0.
REQ-024 Input handshake completes only when in_valid and in_ready are both high; in_data is never captured otherwise.
REQ-025 Adder latency SHALL be unbounded; the block waits indefinitely in ADD_WAIT.
REQ-026 Accumulation order SHALL be strictly arrival order: sum = ((e0+e1)+e2)+...; N elements produce exactly N-1 adder requests.
REQ-027 Throughput SHALL be one element per (adder latency + 2) cycles; no overlap of requests.
REQ-028 Values (NaN, Inf, denormal) SHALL pass through unmodified; no arithmetic is done in this block.

Reset
REQ-029 On reset, state SHALL be IDLE; acc, add_a, add_b, out_data=0; add_en=0; out_valid=0; in_ready=0 during the reset cycle, 1 after.
REQ-030 Reset mid-operation (any state, incl. ADD_WAIT) SHALL abort the group; a later add_ready is ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (fp_accum_state_t) and the FP16 constants FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
REQ-032 SHALL contain no sub-module; floating_point_adder is instantiated beside it by the parent, not inside.

Verification
REQ-033 Single element 16'h4E00 with in_last -> out_data=16'h4E00 one cycle later, add_en never asserted.
REQ-034 Stream 3C00,4000,4200(last), behavioural adder with 3-cycle latency -> two requests (3C00+4000, 4200+4200), out_data=16'h4600.
REQ-035 add_en held high with stable operands for 10 cycles before add_ready -> no extra request, in_ready low throughout.
REQ-036 out_ready held low 5 cycles -> out_valid and out_data stable, in_ready=0; then accept and next group starts from IDLE.
REQ-037 reset asserted in ADD_WAIT, add_ready pulsed after -> outputs at reset values, next group sum unaffected.
